// File: rtl/data_mem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package data_mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_NONE = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_be_gen.sv
// Byte-enable and alignment-error decode for one data-memory request.
module data_mem_be_gen
  import data_mem_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] byte_en,
  output logic       err
);

  always_comb begin
    byte_en = 4'b0000;
    err     = 1'b0;
    case (size)
      SIZE_WORD: begin
        byte_en = 4'b1111;
        err     = (addr_lo != 2'b00);
      end
      SIZE_HALF: begin
        byte_en = addr_lo[1] ? 4'b1100 : 4'b0011;
        err     = addr_lo[0];
      end
      SIZE_BYTE: begin
        byte_en = 4'b0001 << addr_lo;
      end
      default: begin
        // SIZE_NONE never touches the array
        byte_en = 4'b0000;
        err     = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data RAM answering load/store requests after a fixed number
// of wait states, with a one-cycle active-low ready pulse per access.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        require_mem_access,
  input  logic        write,
  input  logic [1:0]  size,
  input  logic [31:0] data_mem_addr,
  input  logic [31:0] data_to_mem,
  output logic        data_mem_access_ready_n,
  output logic [31:0] data_from_mem,
  output logic        access_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  logic [31:0] ram [DEPTH];

  state_t           state;
  logic [CNT_W-1:0] count;

  logic [ADDR_W-1:0] req_idx;
  logic [1:0]        req_lo;
  logic [1:0]        req_size;
  logic              req_write;
  logic [31:0]       req_data;

  logic [ADDR_W-1:0] cur_idx;
  logic [1:0]        cur_lo;
  logic [1:0]        cur_size;
  logic              cur_write;
  logic [31:0]       cur_data;

  logic [3:0] byte_en;
  logic       err;
  logic       enter_done;

  logic unused_addr_hi;
  assign unused_addr_hi = ^data_mem_addr[31:ADDR_W+2];

  // In IDLE the live port values are used so a zero-wait access can complete
  // on the very edge that accepts it; otherwise the latched request applies.
  always_comb begin
    if (state == IDLE) begin
      cur_idx   = data_mem_addr[ADDR_W+1:2];
      cur_lo    = data_mem_addr[1:0];
      cur_size  = size;
      cur_write = write;
      cur_data  = data_to_mem;
    end else begin
      cur_idx   = req_idx;
      cur_lo    = req_lo;
      cur_size  = req_size;
      cur_write = req_write;
      cur_data  = req_data;
    end

    enter_done = 1'b0;
    case (state)
      IDLE:    enter_done = require_mem_access && (WAIT_CYCLES == 0);
      WAIT:    enter_done = require_mem_access && (count == CNT_W'(1));
      default: enter_done = 1'b0;
    endcase
  end

  data_mem_be_gen u_be_gen (
    .size    (cur_size),
    .addr_lo (cur_lo),
    .byte_en (byte_en),
    .err     (err)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && require_mem_access) begin
      req_idx   <= data_mem_addr[ADDR_W+1:2];
      req_lo    <= data_mem_addr[1:0];
      req_size  <= size;
      req_write <= write;
      req_data  <= data_to_mem;
    end
  end

  // Stores commit on the edge entering DONE, so a following load sees them.
  always_ff @(posedge clk) begin
    if (enter_done && cur_write && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) ram[cur_idx][8*b +: 8] <= cur_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                   <= IDLE;
      count                   <= '0;
      data_mem_access_ready_n <= 1'b1;
      data_from_mem           <= 32'h0000_0000;
      access_err              <= 1'b0;
    end else begin
      data_mem_access_ready_n <= !enter_done;
      access_err              <= enter_done && err;
      if (enter_done && !cur_write) data_from_mem <= ram[cur_idx];

      case (state)
        IDLE: begin
          if (require_mem_access) begin
            count <= CNT_W'(WAIT_CYCLES);
            state <= (WAIT_CYCLES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          count <= count - CNT_W'(1);
          if (!require_mem_access)     state <= IDLE;
          else if (count == CNT_W'(1)) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: a zero-wait and a two-wait instance driven
// from directed and random transactions against a byte-lane memory model.
module tb_data_mem_responder;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0 -> WAIT_CYCLES=0 instance, index 1 -> WAIT_CYCLES=2 instance
  logic        rst_n [2];
  logic        req   [2];
  logic        wr    [2];
  logic [1:0]  sz    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ready_n [2];
  logic [31:0] dout    [2];
  logic        aerr    [2];

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .require_mem_access(req[0]), .write(wr[0]),
    .size(sz[0]), .data_mem_addr(addr[0]), .data_to_mem(wdata[0]),
    .data_mem_access_ready_n(ready_n[0]), .data_from_mem(dout[0]), .access_err(aerr[0])
  );

  data_mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n[1]), .require_mem_access(req[1]), .write(wr[1]),
    .size(sz[1]), .data_mem_addr(addr[1]), .data_to_mem(wdata[1]),
    .data_mem_access_ready_n(ready_n[1]), .data_from_mem(dout[1]), .access_err(aerr[1])
  );

  bit [31:0] mem [2][DEPTH];
  int        exp_pulse  [2];
  bit        exp_err    [2];
  bit [31:0] exp_dout   [2];
  bit        pend_valid [2];
  bit [31:0] pend_val   [2];
  int        last_pulse [2];
  bit        last_err   [2];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit checking = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wc(int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  // Every-cycle comparison of both instances against the transaction model.
  always @(negedge clk) begin
    #1;
    if (checking) begin
      for (int d = 0; d < 2; d++) begin
        bit pulse;
        pulse = (cyc == exp_pulse[d]);
        if (pulse && pend_valid[d]) begin
          exp_dout[d]   = pend_val[d];
          pend_valid[d] = 1'b0;
        end
        if (ready_n[d] === 1'b0) begin
          last_pulse[d] = cyc;
          last_err[d]   = aerr[d];
        end
        chk($sformatf("ready_n[%0d]@%0d", d, cyc), 32'(ready_n[d]), 32'(!pulse));
        chk($sformatf("access_err[%0d]@%0d", d, cyc), 32'(aerr[d]), pulse ? 32'(exp_err[d]) : 32'h0);
        chk($sformatf("data_from_mem[%0d]@%0d", d, cyc), dout[d], exp_dout[d]);
      end
    end
  end

  // Issue one request at a negedge; returns at the negedge after its ready cycle.
  task automatic access(int d, bit w, bit [1:0] s, bit [31:0] a, bit [31:0] dat, bit hold);
    int nb;
    bit e;
    int idx;
    nb  = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    e   = (s == 2'd3) || ((a % nb) != 0);
    idx = int'((a >> 2) % DEPTH);
    req[d] = 1'b1; wr[d] = w; sz[d] = s; addr[d] = a; wdata[d] = dat;
    exp_err[d]   = e;
    exp_pulse[d] = cyc + 1 + wc(d);
    if (!w) begin
      pend_val[d]   = mem[d][idx];
      pend_valid[d] = 1'b1;
    end else if (!e) begin
      for (int k = 0; k < nb; k++) begin
        int lane;
        lane = int'(a % 4) + k;
        mem[d][idx][8*lane +: 8] = dat[8*lane +: 8];
      end
    end
    repeat (wc(d) + 1) @(negedge clk);
    if (!hold) req[d] = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_reset(int d);
    rst_n[d] = 1'b0;
    req[d]   = 1'b0;
    exp_pulse[d] = -1; pend_valid[d] = 1'b0; exp_dout[d] = 32'h0; exp_err[d] = 1'b0;
    @(negedge clk);
    #2;
    chk("reset ready_n", 32'(ready_n[d]), 32'h1);
    chk("reset data_from_mem", dout[d], 32'h0000_0000);
    chk("reset access_err", 32'(aerr[d]), 32'h0);
    @(negedge clk);
    rst_n[d] = 1'b1;
    @(negedge clk);
  endtask

  // Start a two-wait store that never completes; returns one cycle into WAIT.
  task automatic start_store_1(bit [31:0] a, bit [31:0] dat);
    req[1] = 1'b1; wr[1] = 1'b1; sz[1] = 2'd0; addr[1] = a; wdata[1] = dat;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, p1, p2, p3;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; req[d] = 1'b0; wr[d] = 1'b0; sz[d] = 2'd0;
      addr[d] = 32'h0; wdata[d] = 32'h0;
      exp_pulse[d] = -1; exp_err[d] = 1'b0; exp_dout[d] = 32'h0;
      pend_valid[d] = 1'b0; last_pulse[d] = -1; last_err[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    checking = 1'b1;
    do_reset(0);
    do_reset(1);

    // Word store/load with two wait states, latency pinned by hand.
    c0 = cyc;
    access(1, 1'b1, 2'd0, 32'h10, 32'h8765_4321, 1'b0);
    chk("sw latency", 32'(last_pulse[1]), 32'(c0 + 3));
    access(1, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0);
    chk("lw 0x10 word", dout[1], 32'h8765_4321);
    chk("lw 0x10 err", 32'(last_err[1]), 32'h0);

    // Byte and half lanes.
    access(1, 1'b1, 2'd0, 32'h10, 32'ha0b1_c2d3, 1'b0);
    access(1, 1'b1, 2'd2, 32'h12, 32'h2121_2121, 1'b0);
    access(1, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0);
    chk("sb 0x12", dout[1], 32'ha021_c2d3);
    access(1, 1'b1, 2'd1, 32'h10, 32'h4321_4321, 1'b0);
    access(1, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0);
    chk("sh 0x10", dout[1], 32'ha021_4321);

    // Misaligned half and no-access size.
    access(1, 1'b1, 2'd1, 32'h13, 32'h9999_9999, 1'b0);
    chk("sh misalign err", 32'(last_err[1]), 32'h1);
    access(1, 1'b1, 2'd3, 32'h10, 32'hffff_ffff, 1'b0);
    chk("size none err", 32'(last_err[1]), 32'h1);
    access(1, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0);
    chk("after err stores", dout[1], 32'ha021_4321);

    // Abort by dropping require, then reset, both mid-wait.
    access(1, 1'b1, 2'd0, 32'h20, 32'h1122_3344, 1'b0);
    start_store_1(32'h20, 32'hdead_beef);
    req[1] = 1'b0;
    repeat (4) @(negedge clk);
    access(1, 1'b0, 2'd0, 32'h20, 32'h0, 1'b0);
    chk("abort keeps 0x20", dout[1], 32'h1122_3344);
    start_store_1(32'h20, 32'hdead_beef);
    do_reset(1);
    access(1, 1'b0, 2'd0, 32'h20, 32'h0, 1'b0);
    chk("reset keeps 0x20", dout[1], 32'h1122_3344);

    // Zero-wait instance: back-to-back with require held, and aliasing.
    access(0, 1'b1, 2'd0, 32'h10, 32'hcafe_f00d, 1'b0);
    access(0, 1'b1, 2'd0, 32'h14, 32'h0102_0304, 1'b1);
    p1 = last_pulse[0];
    access(0, 1'b0, 2'd0, 32'h14, 32'h0, 1'b1);
    p2 = last_pulse[0];
    chk("b2b data", dout[0], 32'h0102_0304);
    access(0, 1'b0, 2'd0, 32'h10, 32'h0, 1'b0);
    p3 = last_pulse[0];
    chk("b2b period 1", 32'(p2 - p1), 32'h2);
    chk("b2b period 2", 32'(p3 - p2), 32'h2);
    chk("b2b last load", dout[0], 32'hcafe_f00d);
    access(0, 1'b0, 2'd0, 32'h10 + 4 * DEPTH, 32'h0, 1'b0);
    chk("alias load", dout[0], 32'hcafe_f00d);
    access(0, 1'b1, 2'd0, 32'h14 + 4 * DEPTH, 32'h55aa_55aa, 1'b0);
    access(0, 1'b0, 2'd0, 32'h14, 32'h0, 1'b0);
    chk("alias store", dout[0], 32'h55aa_55aa);

    // Random traffic over a preloaded window, with aliased addresses.
    for (int d = 0; d < 2; d++) begin
      for (int wi = 0; wi < 16; wi++) begin
        access(d, 1'b1, 2'd0, 32'h40 + 32'(4 * wi), $urandom, 1'b0);
      end
      for (int i = 0; i < 120; i++) begin
        bit [31:0] a;
        bit [1:0]  s;
        bit        w, h;
        a = 32'h40 + ($urandom % 64) + (($urandom % 4) << (ADDR_W + 2));
        s = (($urandom % 8) == 0) ? 2'd3 : 2'($urandom % 3);
        w = 1'($urandom % 2);
        h = (i != 119) && (($urandom % 2) == 1);
        access(d, w, s, a, $urandom, h);
      end
    end

    repeat (3) @(negedge clk);
    checking = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the data-memory interface driven by mem_stage; a word-organised data RAM with a wait-state request/ready handshake.
- Accepts load/store requests (address, size, write, lane-replicated store data) and completes each with a one-cycle active-low ready pulse.
- Loads return the full aligned word; mem_stage does byte/half extraction and sign/zero extension.
- Used as the data-side memory in core-level simulation and as a stall source for pipeline testing.

Parameters:
- ADDR_W, 10, word-address width; array holds 2**ADDR_W 32-bit words.
- WAIT_CYCLES, 2, extra wait states before ready (0 allowed).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- require_mem_access  input  1  request valid; held high by requester until ready pulse.
- write  input  1  1 = store, 0 = load.
- size  input  2  00 word, 01 half, 10 byte, 11 no access.
- data_mem_addr  input  32  byte address.
- data_to_mem  input  32  store data, already replicated across lanes.
- data_mem_access_ready_n  output  1  active-low completion pulse.
- data_from_mem  output  32  aligned read word, registered.
- access_err  output  1  error flag, valid with ready pulse.

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, ready_n=1, data_from_mem=0, access_err=0. RAM contents are not cleared.
- Word index = data_mem_addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2**ADDR_W bytes.
- Byte enables, from the latched request:
  - byte: 1 << addr[1:0].
  - half: 0011 << (2*addr[1]).
  - word: 1111.
- Misalignment and size=11 set err:
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
  - size=11.
- FSM states IDLE, WAIT, DONE:
  - IDLE: on an edge with require=1, latch addr/size/write/data, counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else DONE.
  - WAIT: counter decrements each edge. At 1, go to DONE. If require drops, abort to IDLE: no write, no ready.
  - DONE (one cycle): ready_n=0 and access_err=err.
    - Load: data_from_mem = RAM[index], loaded on the edge entering DONE.
    - Store with err=0: enabled lanes written on the edge entering DONE.
    - Store with err=1: no RAM change.
    - Next state is IDLE unconditionally.
- Latency: request sampled at edge E; ready_n is low for exactly the one cycle following edge E+WAIT_CYCLES.
- data_from_mem holds its last load value through stores and idle periods.
- Back-to-back requests: a request still high in the cycle after DONE is sampled as a new request. Minimum period is WAIT_CYCLES+2 cycles.
- Read-after-write at the same address returns the written data, since the store commits before the next request is sampled.
- Reset mid-operation: any pending store is discarded and ready_n returns to 1 immediately.
- No X propagation: err=1 and read data unaffected when size=11.

Decomposition:
- Package data_mem_pkg:
  - size encodings SIZE_WORD/SIZE_HALF/SIZE_BYTE/SIZE_NONE.
  - state enum IDLE/WAIT/DONE.
- Sub-module data_mem_be_gen, combinational: (size, addr[1:0]) -> 4-bit byte enable plus misalign/err flag.
- RAM array and FSM stay in the top module.

Test Plan:
- Reset check: rst_n=0 mid-run -> ready_n=1, data_from_mem=0000_0000, access_err=0. WAIT_CYCLES=2 assumed below.
- Store/load word: SW addr 0x10 data 8765_4321; ready_n low exactly one cycle, 3 cycles after accept edge. Then LW 0x10 -> data_from_mem=8765_4321, access_err=0.
- Byte and half lanes: preload word 0x10=a0b1_c2d3.
  - SB addr 0x12 data 2121_2121 -> LW 0x10 = a021_c2d3.
  - SH addr 0x10 data 4321_4321 -> LW 0x10 = a021_4321.
- Errors: SH addr 0x13 and size=11 store -> ready pulse with access_err=1; LW 0x10 unchanged.
- Abort and reset mid-wait: drop require during WAIT, or pulse rst_n low, while SW 0x20 data dead_beef. Expect no ready pulse, and LW 0x20 returns the prior value.
- Back-to-back and WAIT_CYCLES=0: consecutive SW/LW held continuously -> ready pulses every 2 cycles; aliasing check LW (0x10 + 4*2**ADDR_W) equals LW 0x10.
